// File: rtl/mult_div.sv
// mult_div: HI/LO multiply/divide unit for the EX stage.
// Results are computed from the operands sampled at the accept edge and held
// in res_hi/res_lo. A fixed down-counter models the pipeline latency: 5 cycles
// for multiplies and 10 for divides. HI/LO are written when the counter reaches zero.
//
// Handshake: an operation is accepted on a rising edge when start=1, IRQ=0 and
// busy=0. While busy=1 start is ignored. An accepted operation always runs to
// completion unless reset is asserted. The hazard unit must stall dependent
// instructions while start||busy; this block never stalls anything itself.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRQ,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        hilo_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mulout
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] LAT_MUL = 4'd5;
    localparam logic [3:0] LAT_DIV = 4'd10;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic [3:0]  r_count;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;

    logic        w_accept;
    logic signed [63:0] w_a_sext;
    logic signed [63:0] w_b_sext;
    logic signed [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_mag_safe;
    logic [31:0] w_b_safe;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_accept = start && !IRQ && !r_busy;

    // Arithmetic datapath: both products plus signed and unsigned quotient/remainder.
    // Signed division works on magnitudes so that 0x80000000 / -1 wraps
    // to 0x80000000 instead of overflowing. The divisor is forced to 1
    // when it is zero; that result is discarded.
    always_comb begin
        w_a_sext     = {{32{a[31]}}, a};
        w_b_sext     = {{32{b[31]}}, b};
        w_prod_s     = w_a_sext * w_b_sext;
        w_prod_u     = {32'd0, a} * {32'd0, b};
        w_a_mag      = a[31] ? (~a + 32'd1) : a;
        w_b_mag      = b[31] ? (~b + 32'd1) : b;
        w_b_mag_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_b_safe     = (b == 32'd0) ? 32'd1 : b;
        w_sq_mag     = w_a_mag / w_b_mag_safe;
        w_sr_mag     = w_a_mag % w_b_mag_safe;
        w_sq         = (a[31] ^ b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
        w_sr         = a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
        w_uq         = a / w_b_safe;
        w_ur         = a % w_b_safe;
    end

    // Select the result to latch for the requested operation.
    // On divide by zero, the current HI/LO is captured, so the commit leaves them unchanged.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (md_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    w_res_hi = w_sr;
                    w_res_lo = w_sq;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    w_res_hi = w_ur;
                    w_res_lo = w_uq;
                end
            end
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    // Accept new operations, count down the latency and commit on the final count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_count  <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else if (r_busy) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                r_hi   <= r_res_hi;
                r_lo   <= r_res_lo;
                r_busy <= 1'b0;
            end
        end else if (w_accept) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    r_res_hi <= w_res_hi;
                    r_res_lo <= w_res_lo;
                    r_busy   <= 1'b1;
                    r_count  <= LAT_MUL;
                end
                OP_DIV, OP_DIVU: begin
                    r_res_hi <= w_res_hi;
                    r_res_lo <= w_res_lo;
                    r_busy   <= 1'b1;
                    r_count  <= LAT_DIV;
                end
                OP_MTHI: r_hi <= a;
                OP_MTLO: r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign hi_out = r_hi;
    assign lo_out = r_lo;
    // The read port is forced to zero during reset.
    assign mulout = reset ? 32'd0 : (hilo_sel ? r_hi : r_lo);

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed-vector bench for mult_div with hand-computed results.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_mult_div;

    logic        clk;
    logic        reset;
    logic        IRQ;
    logic        start;
    logic [2:0]  md_op;
    logic        hilo_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mulout;

    int n_checks;
    int n_errors;
    int cyc;

    mult_div dut (
        .clk      (clk),
        .reset    (reset),
        .IRQ      (IRQ),
        .start    (start),
        .md_op    (md_op),
        .hilo_sel (hilo_sel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .mulout   (mulout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. It drives one request for the next rising edge
    // and returns at the falling edge after that.
    task automatic issue(input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic virq);
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        IRQ   = virq;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
        IRQ   = 1'b0;
        @(negedge clk);
    endtask

    // Counts falling edges at which busy is high. The count is bounded.
    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 30) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Checks HI/LO on the direct outputs and through the read mux.
    task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_hi"}, hi_out, eh);
        chk({tag, "_lo"}, lo_out, el);
        hilo_sel = 1'b1;
        #1;
        chk({tag, "_mulout_hi"}, mulout, eh);
        hilo_sel = 1'b0;
        #1;
        chk({tag, "_mulout_lo"}, mulout, el);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        IRQ      = 1'b0;
        start    = 1'b0;
        md_op    = 3'd0;
        hilo_sel = 1'b1;
        a        = 32'd0;
        b        = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_mulout", mulout, 32'd0);
        reset    = 1'b0;
        hilo_sel = 1'b0;
        @(negedge clk);

        // MTLO 0x55
        issue(3'd6, 32'h55, 32'd0, 1'b0);
        chk("mtlo_lo", lo_out, 32'h55);
        chk("mtlo_mulout", mulout, 32'h55);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // MTHI under IRQ is dropped
        issue(3'd5, 32'h1234, 32'd0, 1'b1);
        chk("mthi_irq_hi", hi_out, 32'd0);

        // MULT -2 * 3
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_hi_hold", hi_out, 32'd0);
        wait_busy(cyc);
        chk("mult_busy_cyc", cyc, 5);
        chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        // MULTU 0xFFFFFFFF * 2
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_busy(cyc);
        chk("multu_busy_cyc", cyc, 5);
        chk_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

        // DIV -7 / 2
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_busy(cyc);
        chk("div_busy_cyc", cyc, 10);
        chk_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // DIV overflow corner
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_busy(cyc);
        chk("div_ovf_cyc", cyc, 10);
        chk_hilo("div_ovf", 32'h0, 32'h80000000);

        // DIV 7 / -2 -> q=-3 r=1
        issue(3'd3, 32'd7, 32'hFFFFFFFE, 1'b0);
        wait_busy(cyc);
        chk_hilo("div_negb", 32'd1, 32'hFFFFFFFD);

        // DIVU 100 / 7 -> q=14 r=2
        issue(3'd4, 32'd100, 32'd7, 1'b0);
        wait_busy(cyc);
        chk("divu_busy_cyc", cyc, 10);
        chk_hilo("divu", 32'd2, 32'd14);

        // DIVU by zero keeps HI/LO
        issue(3'd5, 32'h11, 32'd0, 1'b0);
        issue(3'd6, 32'h22, 32'd0, 1'b0);
        issue(3'd4, 32'd7, 32'd0, 1'b0);
        wait_busy(cyc);
        chk("divz_busy_cyc", cyc, 10);
        chk_hilo("divz", 32'h11, 32'h22);

        // MULT with IRQ and a stray MTLO during busy
        issue(3'd1, 32'h10, 32'h20, 1'b0);
        @(negedge clk);
        IRQ   = 1'b1;
        start = 1'b1;
        md_op = 3'd6;
        a     = 32'hDEAD;
        @(negedge clk);
        IRQ   = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        chk("irq_busy_mid", {31'd0, busy}, 32'd1);
        wait_busy(cyc);
        chk("irq_busy_rest", cyc, 3);
        chk_hilo("irq_mult", 32'h0, 32'h200);

        // Back-to-back: accept in the first cycle busy reads 0
        issue(3'd2, 32'd3, 32'd5, 1'b0);
        wait_busy(cyc);
        chk("b2b_busy_cyc", cyc, 5);
        chk_hilo("b2b", 32'h0, 32'd15);

        // No-op codes change nothing
        issue(3'd0, 32'hAAAA, 32'd1, 1'b0);
        issue(3'd7, 32'hBBBB, 32'd1, 1'b0);
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk_hilo("noop", 32'h0, 32'd15);

        // Reset in the middle of a MULT
        issue(3'd5, 32'hAA, 32'd0, 1'b0);
        issue(3'd1, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        chk("midrst_mulout", mulout, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // The first edge after release accepts an MTLO.
        issue(3'd6, 32'h77, 32'd0, 1'b0);
        chk("post_rst_lo", lo_out, 32'h77);
        repeat (8) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk_hilo("post_rst", 32'h0, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL use one clock and asynchronous, active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous, active-high).
REQ-002 SHALL have the following ports.
- IRQ  input  1  Exception/interrupt flush for the EX-stage instruction.
- start  input  1  EX-stage instruction is a multiply/divide/move-to operation.
- md_op  input  3  Operation: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-op.
- hilo_sel  input  1  Read select: 1 = HI, 0 = LO.
- a  input  32  rs operand, already forwarded.
- b  input  32  rt operand, already forwarded.
- busy  output  1  Operation in progress; registered.
- hi_out  output  32  HI register.
- lo_out  output  32  LO register.
- mulout  output  32  Read data for MFHI/MFLO; feeds the EX/ME mulout input.

Function
REQ-003 SHALL hold state in: HI[31:0], LO[31:0], busy, count[3:0], and latched result registers res_hi and res_lo.
REQ-004 SHALL drive mulout combinationally as hilo_sel ? HI : LO, with zero added latency.
REQ-005 SHALL define accept as start && !IRQ && !busy.
REQ-006 SHALL ignore start when IRQ=1 or busy=1; state is unchanged.
REQ-007 SHALL, on accept with md_op 1-4:
- compute the result from a and b sampled at that edge;
- set busy=1;
- load count=5 for MULT/MULTU, 10 for DIV/DIVU.
REQ-008 SHALL, on accept with md_op 5 (MTHI), write HI<=a at that edge; busy stays 0.
REQ-009 SHALL, on accept with md_op 6 (MTLO), write LO<=a at that edge; busy stays 0.
REQ-010 SHALL, on accept with md_op 0 or 7, change no state.
REQ-011 SHALL, while busy=1, decrement count each edge.
REQ-012 SHALL, on the edge where count goes 1->0:
- write HI<=res_hi and LO<=res_lo;
- clear busy.
REQ-013 SHALL make the new HI/LO visible on hi_out/lo_out/mulout in the cycle busy first reads 0.
REQ-014 SHALL therefore keep busy high for exactly 5 cycles (multiply) or 10 cycles (divide) after the accept edge.
REQ-015 SHALL NOT let IRQ abort an operation already accepted; it runs to completion and commits.
REQ-016 SHALL form MULT results as the signed 64-bit product of a and b, with HI = bits [63:32] and LO = bits [31:0].
REQ-017 SHALL form MULTU results as the unsigned 64-bit product, split the same way.
REQ-018 SHALL form DIV results with:
- LO = quotient, truncated toward zero;
- HI = remainder, with the sign of the dividend.
REQ-019 SHALL, for DIV with a=0x80000000 and b=0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-020 SHALL form DIVU results as unsigned LO=a/b and HI=a%b.
REQ-021 SHALL, for DIV or DIVU with b=0, still assert busy for 10 cycles but leave HI and LO unchanged at completion.
REQ-022 SHALL, on an accept in the same cycle busy falls to 0 (count=0 after completion), proceed normally; back-to-back operations are legal.
REQ-023 SHALL expose busy and start so that the hazard unit stalls MFHI/MFLO/MTHI/MTLO/MULT/DIV in EX while start||busy; this block performs no stalling itself.

Reset
REQ-024 SHALL, on reset assertion and independent of clk, force HI=0, LO=0, busy=0, count=0, res_hi=0 and res_lo=0.
REQ-025 SHALL drive mulout=0 while reset is asserted.
REQ-026 SHALL abandon an operation in progress on mid-operation reset; no commit occurs after reset releases.
REQ-027 SHALL take its first possible accept on the first rising edge after reset deasserts.

Verification
REQ-028 SHALL cover: MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 SHALL cover: DIVU a=7, b=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-032 SHALL cover: MTHI a=0x1234 with IRQ=1 -> HI unchanged.
REQ-033 SHALL cover: MTLO a=0x55 with IRQ=0 -> LO=0x55 next edge; mulout=0x55 with hilo_sel=0.
REQ-034 SHALL cover: MULT accepted, IRQ pulsed on cycle 2 -> still commits at cycle 5.
REQ-035 SHALL cover: MULT accepted, reset pulsed on cycle 3 -> HI=LO=0 and busy=0 immediately, and they remain 0.
